decrypt: RTL and testbench
==========================

DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 Parameter PLAINTEXT_MODULUS, 64: plaintext modulus p; power of two.
REQ-002 Parameter PLAINTEXT_WIDTH, 6: log2(p).
REQ-003 Parameter CIPHERTEXT_MODULUS, 1024: ciphertext modulus q; power of two, q > p.
REQ-004 Parameter CIPHERTEXT_WIDTH, 10: log2(q).
REQ-005 Parameter DIMENSION, 10: number of a-entries per ciphertext vector (n).
REQ-006 Parameter DIM_WIDTH, 4: index width; must hold values 0..DIMENSION.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 in_valid  input  1  ciphertext element and key entry valid this cycle.
REQ-010 in_ready  output  1  block accepts an element this cycle.
REQ-011 ct_entry  input  CIPHERTEXT_WIDTH  ciphertext element; element 0 is c0 (b term), elements 1..n are a_i.
REQ-012 sk_entry  input  CIPHERTEXT_WIDTH  secret key s_i paired with a_i; ignored for element 0.
REQ-013 flush  input  1  synchronous abort of the vector in progress.
REQ-014 out_valid  output  1  decoded plaintext available.
REQ-015 out_ready  input  1  downstream accepts plaintext.
REQ-016 plaintext  output  PLAINTEXT_WIDTH  decoded message.

Function
REQ-017 Element transfer occurs on a cycle with in_valid=1 and in_ready=1; no other cycle changes the accumulator or index.
REQ-018 FSM has two states: ACCUM (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-019 In ACCUM, internal index idx starts at 0; each transfer increments idx; the transfer with idx=DIMENSION moves the FSM to OUT on the same edge and clears idx to 0.
REQ-020 Transfer at idx=0 loads acc <= ct_entry (prior value discarded).
REQ-021 Transfer at idx=k, 1<=k<=n, performs acc <= acc - (ct_entry*sk_entry mod q) mod q; the product keeps only its low CIPHERTEXT_WIDTH bits; subtraction wraps modulo q.
REQ-022 Latency: out_valid rises the cycle after the element with idx=DIMENSION is accepted.
REQ-023 Decode: plaintext = ((acc + R) mod q) >> (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH), where R is defined in Configuration; the result is registered and held constant while in OUT.
REQ-024 In OUT, out_valid stays 1 and plaintext stays stable until out_valid=1 and out_ready=1; on that edge the FSM returns to ACCUM with idx=0.
REQ-025 No input element is accepted in the cycle of the output handshake (in_ready=0 in OUT); the first element of the next vector is accepted no earlier than the following cycle.
REQ-026 flush=1 in ACCUM clears idx to 0 and discards any element presented that cycle; flush in OUT is ignored.
REQ-027 in_valid deasserted mid-vector stalls: idx and acc hold indefinitely.

Reset
REQ-028 rst_n=0 asynchronously forces FSM=ACCUM, idx=0, acc=0, plaintext=0, out_valid=0; in_ready=1 as soon as rst_n=1.
REQ-029 Reset mid-vector or in OUT discards all partial and pending results; no output handshake follows for the aborted vector.

Configuration
REQ-030 Macro DECRYPT_ROUND_EN defined: R = q/(2p) (round-to-nearest decode).
REQ-031 Macro DECRYPT_ROUND_EN undefined: R = 0 (truncating decode); all other behaviour identical.

Verification (defaults p=64, q=1024, n=10; all a_i, s_i zero unless stated)
REQ-032 c0=264 -> plaintext=17 with DECRYPT_ROUND_EN, 16 without; out_valid exactly 1 cycle after 11th transfer.
REQ-033 c0=95, a1=3, s1=5 -> acc=80, plaintext=5 (both configurations).
REQ-034 Wrap: c0=0, a1=1, s1=1 -> acc=1023, plaintext=0 with DECRYPT_ROUND_EN, 63 without; a1=s1=1023 -> product low bits 1, same result.
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and plaintext stable, in_ready=0, extra in_valid pulses ignored; handshake then next vector decodes correctly.
REQ-036 rst_n low after 4 transfers, or flush=1 after 4 transfers -> idx=0, out_valid=0; a fresh full vector c0=264 then yields 17 (round) with no stale contribution.

Source files
------------

// File: rtl/decrypt.sv
// Streaming LWE decryptor: accumulates c0 - sum(a_i*s_i) mod q over n+1 elements and decodes the top bits.
// Define DECRYPT_ROUND_EN for round-to-nearest decode; leave it undefined for truncating decode.
module decrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int DIM_WIDTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_entry,
  input  logic [CIPHERTEXT_WIDTH-1:0] sk_entry,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext
);

`ifdef DECRYPT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
  // q/(2p) is half of one plaintext step in ciphertext units.
  localparam logic [CIPHERTEXT_WIDTH-1:0] RND =
    CIPHERTEXT_WIDTH'(ROUND_EN ? CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS) : 0);
  localparam logic [DIM_WIDTH-1:0] LAST_IDX = DIM_WIDTH'(DIMENSION);

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  state_t                        state_q;
  logic [DIM_WIDTH-1:0]          idx_q;
  logic [CIPHERTEXT_WIDTH-1:0]   acc_q;
  logic [CIPHERTEXT_WIDTH-1:0]   acc_d;
  logic [PLAINTEXT_WIDTH-1:0]    pt_q;

  function automatic logic [CIPHERTEXT_WIDTH-1:0] mulmod(
    input logic [CIPHERTEXT_WIDTH-1:0] a,
    input logic [CIPHERTEXT_WIDTH-1:0] b
  );
    logic [CIPHERTEXT_WIDTH-1:0] p;
    p = a * b;
    return p;
  endfunction

  function automatic logic [PLAINTEXT_WIDTH-1:0] decode(
    input logic [CIPHERTEXT_WIDTH-1:0] a
  );
    logic [CIPHERTEXT_WIDTH-1:0] s;
    s = a + RND;
    return s[CIPHERTEXT_WIDTH-1:SHIFT];
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (idx_q == '0) acc_d = ct_entry;
    else             acc_d = acc_q - mulmod(ct_entry, sk_entry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
      pt_q    <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (flush) begin
            idx_q <= '0;
          end else if (in_valid) begin
            acc_q <= acc_d;
            // Decode from the freshly accumulated value so the result is ready on entry to OUT.
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= OUT;
              pt_q    <= decode(acc_d);
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign plaintext = pt_q;

endmodule

// File: tb/tb_decrypt.sv
// Directed bench for decrypt; expected plaintexts follow the DECRYPT_ROUND_EN setting of the build.
module tb_decrypt;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] ct_entry = '0;
  logic [9:0] sk_entry = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] plaintext;

  int vectors = 0;
  int miscompares = 0;

`ifdef DECRYPT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  decrypt dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ct_entry(ct_entry), .sk_entry(sk_entry), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Tasks start and end just after a falling edge; the transfer happens on the rising edge between.
  task automatic xfer(input logic [9:0] ct, input logic [9:0] sk);
    in_valid = 1'b1; ct_entry = ct; sk_entry = sk;
    @(negedge clk);
    in_valid = 1'b0; ct_entry = '0; sk_entry = '0;
  endtask

  task automatic send_vec(input string tag, input logic [9:0] c0, input int k,
                          input logic [9:0] ak, input logic [9:0] sk);
    xfer(c0, 10'd0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) chk({tag, "_ov_before_last"}, int'(out_valid), 0);
      if (i == k) xfer(ak, sk);
      else        xfer(10'd0, 10'd0);
    end
  endtask

  task automatic take_out(input string tag, input int exp_pt);
    chk({tag, "_ov"}, int'(out_valid), 1);
    chk({tag, "_pt"}, int'(plaintext), exp_pt);
    chk({tag, "_ir_out"}, int'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, int'(out_valid), 0);
    chk({tag, "_ir_after"}, int'(in_ready), 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_pt", int'(plaintext), 0);
    chk("rst_ir", int'(in_ready), 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ir", int'(in_ready), 1);

    // c0=264: 264+8=272 -> 17 rounded, 264 -> 16 truncated
    send_vec("v264", 10'd264, 0, 10'd0, 10'd0);
    take_out("v264", RND ? 17 : 16);

    // 95 - 3*5 = 80 -> 5 either way
    send_vec("v95", 10'd95, 1, 10'd3, 10'd5);
    take_out("v95", 5);

    // 0 - 1 wraps to 1023: (1023+8) mod 1024 = 7 -> 0, truncated 63
    send_vec("wrap1", 10'd0, 1, 10'd1, 10'd1);
    take_out("wrap1", RND ? 0 : 63);
    // 1023*1023 low 10 bits = 1
    send_vec("wrap2", 10'd0, 1, 10'd1023, 10'd1023);
    take_out("wrap2", RND ? 0 : 63);

    // last element contributes: 264 - 2*4 = 256 -> 16 both ways
    send_vec("last", 10'd264, 10, 10'd2, 10'd4);
    take_out("last", 16);

    // Backpressure with ignored in_valid pulses, then flush in OUT ignored
    send_vec("bp", 10'd264, 0, 10'd0, 10'd0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; ct_entry = 10'd500; sk_entry = 10'd7;
      flush = (c == 2);
      @(negedge clk);
      chk("bp_ov", int'(out_valid), 1);
      chk("bp_pt", int'(plaintext), RND ? 17 : 16);
      chk("bp_ir", int'(in_ready), 0);
    end
    in_valid = 1'b0; flush = 1'b0; ct_entry = '0; sk_entry = '0;
    take_out("bp", RND ? 17 : 16);
    send_vec("bp_next", 10'd95, 1, 10'd3, 10'd5);
    take_out("bp_next", 5);

    // Stall mid-vector: 200 - 6*7 = 158 -> (166>>4)=10 rounded, 9 truncated
    xfer(10'd200, 10'd0);
    xfer(10'd0, 10'd0);
    repeat (3) @(negedge clk);
    xfer(10'd6, 10'd7);
    for (int i = 3; i <= 10; i++) xfer(10'd0, 10'd0);
    take_out("stall", RND ? 10 : 9);

    // Asynchronous reset after 4 transfers
    xfer(10'd500, 10'd0);
    xfer(10'd7, 10'd9);
    xfer(10'd0, 10'd0);
    xfer(10'd0, 10'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_pt", int'(plaintext), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_vec("after_rst", 10'd264, 0, 10'd0, 10'd0);
    take_out("after_rst", RND ? 17 : 16);

    // Flush after 4 transfers, element presented with flush is discarded
    xfer(10'd500, 10'd0);
    xfer(10'd7, 10'd9);
    xfer(10'd0, 10'd0);
    xfer(10'd0, 10'd0);
    flush = 1'b1; in_valid = 1'b1; ct_entry = 10'd300; sk_entry = 10'd300;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; ct_entry = '0; sk_entry = '0;
    chk("flush_ov", int'(out_valid), 0);
    chk("flush_ir", int'(in_ready), 1);
    send_vec("after_flush", 10'd264, 0, 10'd0, 10'd0);
    take_out("after_flush", RND ? 17 : 16);

    // Reset while holding an output: no handshake follows
    send_vec("rst_out", 10'd95, 1, 10'd3, 10'd5);
    chk("rst_out_ov", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_ov0", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_ov_stay0", int'(out_valid), 0);
    chk("rst_out_ir", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
